// File: rtl/eth_rx_dispatch_if.sv
// Receive byte stream in, steered payload beats out.
// The same bus carries both the MAC side (rx_*) and the client side (out_*, *_valid).
// master = the block that feeds rx_* and consumes the beats; slave = the dispatcher.
interface eth_rx_dispatch_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_sof;
  logic        rx_last;
  logic        rx_err;

  logic [7:0]  out_data;
  logic        out_last;
  logic        out_err;
  logic        arp_valid;
  logic        ipv4_valid;
  logic [47:0] out_srcmac;
  logic [15:0] out_ethertype;

  modport master (
    output rx_data, rx_valid, rx_sof, rx_last, rx_err,
    input  out_data, out_last, out_err, arp_valid, ipv4_valid, out_srcmac, out_ethertype
  );

  modport slave (
    input  rx_data, rx_valid, rx_sof, rx_last, rx_err,
    output out_data, out_last, out_err, arp_valid, ipv4_valid, out_srcmac, out_ethertype
  );
endinterface

// File: rtl/eth_rx_dispatch.sv
// Ethernet RX dispatch: parse 14-byte header, filter on dst MAC, steer payload to ARP/IPv4.
// Latency: every payload byte appears as an out beat exactly 1 cycle after it is accepted.
// Backpressure: none; clients must take every beat, gaps on rx_valid are mirrored on the outputs.
// Ports: clk, resetn (async, active-low); bus (slave side: rx_* in, out_*/arp_valid/ipv4_valid out);
//        arp_cnt / ipv4_cnt (good frames delivered), drop_cnt (filter miss, unknown type, runt).
module eth_rx_dispatch #(
  parameter logic [47:0] LOCALMAC = 48'h000000000000,
  parameter int          CNTW     = 16
) (
  input  logic            clk,
  input  logic            resetn,
  eth_rx_dispatch_if.slave bus,
  output logic [CNTW-1:0] arp_cnt,
  output logic [CNTW-1:0] ipv4_cnt,
  output logic [CNTW-1:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, HDR, FWD, DROP} state_t;

  localparam logic [15:0] ET_ARP  = 16'h0806;
  localparam logic [15:0] ET_IPV4 = 16'h0800;

  state_t        state_q, state_d;
  logic [3:0]    idx_q;        // index of the byte expected next while in HDR
  logic [103:0]  hdr_q;        // header bytes 0..12, byte 0 in the top bits
  logic          tgt_ipv4_q;   // client of the frame being forwarded (0 = ARP)

  logic [47:0]   hdr_dst;
  logic [15:0]   hdr_type;
  logic          mac_ok;

  logic          fwd_enter, fwd_ipv4;
  logic          beat, abort, good;
  logic          drop_a, drop_b;   // two drop events can land in one cycle
  logic [1:0]    drop_n;

  assign hdr_dst  = hdr_q[103:56];
  // Byte 13 is still on rx_data in the decision cycle, so the type is completed from the bus.
  assign hdr_type = {hdr_q[7:0], bus.rx_data};
  assign mac_ok   = (hdr_dst == LOCALMAC) || (hdr_dst == 48'hffff_ffff_ffff);
  assign drop_n   = {1'b0, drop_a} + {1'b0, drop_b};

  function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] c, input logic [1:0] n);
    logic [CNTW:0] s;
    s = {1'b0, c} + {{(CNTW-1){1'b0}}, n};
    return s[CNTW] ? {CNTW{1'b1}} : s[CNTW-1:0];
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    fwd_enter = 1'b0;
    fwd_ipv4  = 1'b0;
    beat      = 1'b0;
    abort     = 1'b0;
    good      = 1'b0;
    drop_a    = 1'b0;
    drop_b    = 1'b0;
    if (bus.rx_valid) begin
      if (bus.rx_sof) begin
        // A new frame start wins in every state.
        abort  = (state_q == FWD);
        drop_a = (state_q == HDR);   // interrupted header is a runt
        if (bus.rx_last) begin
          drop_b  = 1'b1;            // one-byte frame
          state_d = IDLE;
        end else begin
          state_d = HDR;
        end
      end else begin
        case (state_q)
          IDLE: ;
          HDR: begin
            if (bus.rx_last) begin
              drop_a  = 1'b1;        // ended at or before byte 13
              state_d = IDLE;
            end else if (idx_q == 4'd13) begin
              if (mac_ok && hdr_type == ET_ARP) begin
                state_d   = FWD;
                fwd_enter = 1'b1;
              end else if (mac_ok && hdr_type == ET_IPV4) begin
                state_d   = FWD;
                fwd_enter = 1'b1;
                fwd_ipv4  = 1'b1;
              end else begin
                state_d = DROP;
                drop_a  = 1'b1;
              end
            end
          end
          FWD: begin
            beat = 1'b1;
            if (bus.rx_last) begin
              state_d = IDLE;
              good    = !bus.rx_err;
            end
          end
          DROP: begin
            if (bus.rx_last) state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_q             <= 4'd0;
      hdr_q             <= '0;
      tgt_ipv4_q        <= 1'b0;
      bus.out_data      <= 8'h00;
      bus.out_last      <= 1'b0;
      bus.out_err       <= 1'b0;
      bus.arp_valid     <= 1'b0;
      bus.ipv4_valid    <= 1'b0;
      bus.out_srcmac    <= '0;
      bus.out_ethertype <= '0;
      arp_cnt           <= '0;
      ipv4_cnt          <= '0;
      drop_cnt          <= '0;
    end else begin
      if (bus.rx_valid) begin
        if (bus.rx_sof) idx_q <= 4'd1;
        else if (state_q == HDR && idx_q != 4'd13) idx_q <= idx_q + 4'd1;
        // Only bytes 0..12 are shifted in, so 13 fresh bytes fully replace any stale header.
        if (bus.rx_sof || (state_q == HDR && idx_q < 4'd13))
          hdr_q <= {hdr_q[95:0], bus.rx_data};
      end

      if (fwd_enter) begin
        tgt_ipv4_q        <= fwd_ipv4;
        bus.out_srcmac    <= hdr_q[55:8];
        bus.out_ethertype <= hdr_type;
      end

      bus.out_data   <= 8'h00;
      bus.out_last   <= 1'b0;
      bus.out_err    <= 1'b0;
      bus.arp_valid  <= 1'b0;
      bus.ipv4_valid <= 1'b0;
      if (beat) begin
        bus.out_data   <= bus.rx_data;
        bus.out_last   <= bus.rx_last;
        bus.out_err    <= bus.rx_last & bus.rx_err;
        bus.arp_valid  <= !tgt_ipv4_q;
        bus.ipv4_valid <= tgt_ipv4_q;
      end else if (abort) begin
        // Close the interrupted frame toward its client as an errored last beat.
        bus.out_last   <= 1'b1;
        bus.out_err    <= 1'b1;
        bus.arp_valid  <= !tgt_ipv4_q;
        bus.ipv4_valid <= tgt_ipv4_q;
      end

      if (good && !tgt_ipv4_q) arp_cnt  <= sat_add(arp_cnt, 2'd1);
      if (good &&  tgt_ipv4_q) ipv4_cnt <= sat_add(ipv4_cnt, 2'd1);
      if (drop_a || drop_b)    drop_cnt <= sat_add(drop_cnt, drop_n);
    end
  end

endmodule

// File: tb/tb_eth_rx_dispatch.sv
module tb_eth_rx_dispatch;
  localparam logic [47:0] LM   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BC   = 48'hff_ff_ff_ff_ff_ff;
  localparam logic [47:0] M2   = 48'h02_00_00_00_00_02;
  localparam int          CNTW = 3;
  localparam int          CMAX = 7;
  localparam int          NV   = 22;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  eth_rx_dispatch_if bus();
  logic [CNTW-1:0] arp_cnt, ipv4_cnt, drop_cnt;

  eth_rx_dispatch #(.LOCALMAC(LM), .CNTW(CNTW)) dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .arp_cnt(arp_cnt), .ipv4_cnt(ipv4_cnt), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [47:0] dst; logic [15:0] et; int len; int cut; bit gap; bit err;
    int beats; int darp; int dip; int ddrop;
  } vec_t;
  typedef struct {
    bit ipv4; logic [7:0] data; bit last; bit err; logic [47:0] src; logic [15:0] et; int cyc;
  } beat_t;

  vec_t  vecs[NV];
  beat_t exp_q[$];
  beat_t got_q[$];
  int    tests = 0, fails = 0, cyc = 0;
  int    m_arp = 0, m_ip = 0, m_drop = 0;
  bit    pend_abort = 0;
  beat_t pend_beat;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resetn && (bus.arp_valid || bus.ipv4_valid)) begin
      got_q.push_back('{bus.ipv4_valid, bus.out_data, bus.out_last, bus.out_err,
                        bus.out_srcmac, bus.out_ethertype, cyc});
      tests++;
      if (bus.arp_valid && bus.ipv4_valid) begin
        fails++;
        $display("FAIL valid_excl: arp_valid=1 ipv4_valid=1 at cycle %0d, required at most one", cyc);
      end
    end
  end

  function automatic logic [47:0] src_of(input int k);
    return 48'hA0_B1_C2_D3_E4_00 | 48'(k);
  endfunction

  function automatic logic [7:0] fbyte(input int k, input int i, input vec_t v);
    logic [47:0] s;
    s = src_of(k);
    if (i < 6)   return v.dst[47-8*i -: 8];
    if (i < 12)  return s[47-8*(i-6) -: 8];
    if (i == 12) return v.et[15:8];
    if (i == 13) return v.et[7:0];
    return 8'(i*13 + k*29 + 1);
  endfunction

  task automatic drive(input logic [7:0] d, input bit sof, input bit last, input bit err);
    @(posedge clk); #1;
    bus.rx_valid = 1'b1; bus.rx_data = d; bus.rx_sof = sof; bus.rx_last = last; bus.rx_err = err;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.rx_sof = 1'b0; bus.rx_last = 1'b0; bus.rx_err = 1'b0;
    end
  endtask

  task automatic send_frame(input int k);
    vec_t v;
    int n;
    bit ok, ip, last;
    logic [7:0] b;
    v  = vecs[k];
    n  = (v.cut != 0) ? v.cut : v.len;
    ip = (v.et == 16'h0800);
    ok = (v.dst == LM || v.dst == BC) && (v.et == 16'h0800 || v.et == 16'h0806);
    for (int i = 0; i < n; i++) begin
      if (v.gap && i > 0 && $urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      b    = fbyte(k, i, v);
      last = (v.cut == 0) && (i == n - 1);
      drive(b, i == 0, last, v.err && last);
      if (i == 0 && pend_abort) begin
        pend_beat.cyc = cyc + 1;
        exp_q.push_back(pend_beat);
        pend_abort = 0;
      end
      if (ok && i >= 14) exp_q.push_back('{ip, b, last, v.err && last, src_of(k), v.et, cyc + 1});
    end
    if (v.cut > 14 && ok) begin
      pend_abort = 1;
      pend_beat  = '{ip, 8'h00, 1'b1, 1'b1, src_of(k), v.et, 0};
    end
    idle(3);
  endtask

  function automatic bit beq(input beat_t a, input beat_t b);
    return a.ipv4 == b.ipv4 && a.data == b.data && a.last == b.last && a.err == b.err &&
           a.src == b.src && a.et == b.et && a.cyc == b.cyc;
  endfunction

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  task automatic check_cnt(input int k);
    tests++;
    if (int'(arp_cnt) != m_arp) begin
      fails++; $display("FAIL arp_cnt[%0d]: got %0d want %0d", k, arp_cnt, m_arp);
    end
    tests++;
    if (int'(ipv4_cnt) != m_ip) begin
      fails++; $display("FAIL ipv4_cnt[%0d]: got %0d want %0d", k, ipv4_cnt, m_ip);
    end
    tests++;
    if (int'(drop_cnt) != m_drop) begin
      fails++; $display("FAIL drop_cnt[%0d]: got %0d want %0d", k, drop_cnt, m_drop);
    end
  endtask

  task automatic check_frame(input int k);
    vec_t v;
    int bad, n;
    v = vecs[k];
    m_arp  = sat(m_arp + v.darp);
    m_ip   = sat(m_ip + v.dip);
    m_drop = sat(m_drop + v.ddrop);
    tests++;
    if (got_q.size() != v.beats) begin
      fails++; $display("FAIL beat_count[%0d]: got %0d want %0d", k, got_q.size(), v.beats);
    end
    bad = -1;
    n   = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (bad < 0 && !beq(got_q[i], exp_q[i])) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL beats[%0d] #%0d: got ip=%0d d=%h l=%0d e=%0d src=%h et=%h cyc=%0d want ip=%0d d=%h l=%0d e=%0d src=%h et=%h cyc=%0d",
               k, bad, got_q[bad].ipv4, got_q[bad].data, got_q[bad].last, got_q[bad].err,
               got_q[bad].src, got_q[bad].et, got_q[bad].cyc, exp_q[bad].ipv4, exp_q[bad].data,
               exp_q[bad].last, exp_q[bad].err, exp_q[bad].src, exp_q[bad].et, exp_q[bad].cyc);
    end else if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL beats[%0d]: got %0d beats want %0d", k, got_q.size(), exp_q.size());
    end
    check_cnt(k);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string name);
    tests++;
    if (bus.arp_valid !== 1'b0 || bus.ipv4_valid !== 1'b0 || bus.out_data !== 8'h00 ||
        bus.out_last !== 1'b0 || bus.out_err !== 1'b0 || bus.out_srcmac !== 48'h0 ||
        bus.out_ethertype !== 16'h0 || arp_cnt !== '0 || ipv4_cnt !== '0 || drop_cnt !== '0) begin
      fails++;
      $display("FAIL %s: got av=%b iv=%b d=%h l=%b e=%b src=%h et=%h cnt=%0d/%0d/%0d, want all zero",
               name, bus.arp_valid, bus.ipv4_valid, bus.out_data, bus.out_last, bus.out_err,
               bus.out_srcmac, bus.out_ethertype, arp_cnt, ipv4_cnt, drop_cnt);
    end
  endtask

  initial begin
    //           dst  type      len cut gap err beats arp ip drop
    vecs[0]  = '{BC, 16'h0806, 60,  0, 0, 0, 46, 1, 0, 0};
    vecs[1]  = '{LM, 16'h0800, 64,  0, 1, 0, 50, 0, 1, 0};
    vecs[2]  = '{M2, 16'h0800, 64,  0, 0, 0,  0, 0, 0, 1};
    vecs[3]  = '{LM, 16'h86DD, 64,  0, 1, 0,  0, 0, 0, 1};
    vecs[4]  = '{LM, 16'h0800, 64,  0, 0, 0, 50, 0, 1, 0};
    vecs[5]  = '{LM, 16'h0800, 11,  0, 0, 0,  0, 0, 0, 1};
    vecs[6]  = '{LM, 16'h0800, 64,  5, 0, 0,  0, 0, 0, 0};
    vecs[7]  = '{LM, 16'h0800, 64,  0, 0, 0, 50, 0, 1, 1};
    vecs[8]  = '{M2, 16'h0800, 64, 20, 0, 0,  0, 0, 0, 1};
    vecs[9]  = '{LM, 16'h0806, 60,  0, 0, 0, 46, 1, 0, 0};
    vecs[10] = '{LM, 16'h0800, 64, 34, 0, 0, 20, 0, 0, 0};
    vecs[11] = '{LM, 16'h0800, 64,  0, 1, 0, 51, 0, 1, 0};
    vecs[12] = '{LM, 16'h0800, 40,  0, 0, 1, 26, 0, 0, 0};
    vecs[13] = '{BC, 16'h0800, 15,  0, 0, 0,  1, 0, 1, 0};
    vecs[14] = '{LM, 16'h0806, 14,  0, 0, 0,  0, 0, 0, 1};
    vecs[15] = '{LM, 16'h0800,  1,  0, 0, 0,  0, 0, 0, 1};
    vecs[16] = '{LM, 16'h0800, 30,  0, 1, 0, 16, 0, 1, 0};
    vecs[17] = '{BC, 16'h0800, 30,  0, 0, 0, 16, 0, 1, 0};
    vecs[18] = '{LM, 16'h0800, 30,  0, 0, 0, 16, 0, 1, 0};
    vecs[19] = '{M2, 16'h0806, 30,  0, 0, 0,  0, 0, 0, 1};
    vecs[20] = '{LM, 16'h0800, 64, 30, 0, 0, 16, 0, 0, 0};
    vecs[21] = '{LM, 16'h0800, 64,  0, 0, 0, 50, 0, 1, 0};

    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.rx_sof = 1'b0; bus.rx_last = 1'b0; bus.rx_err = 1'b0;
    #3 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #2 check_all_zero("reset_state");
    @(posedge clk); #1 resetn = 1'b1;

    // Bytes without a preceding sof are ignored after reset.
    for (int i = 0; i < 20; i++) drive(8'(i + 14), 1'b0, i == 19, 1'b0);
    idle(3);
    tests++;
    if (got_q.size() != 0) begin
      fails++; $display("FAIL no_sof_ignored: got %0d beats want 0", got_q.size());
    end
    check_cnt(-1);
    got_q.delete();

    for (int k = 0; k < 20; k++) begin
      send_frame(k);
      check_frame(k);
    end

    // Reset in the middle of a forwarded frame.
    send_frame(20);
    check_frame(20);
    drive(8'h5A, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    tests++;
    if (bus.ipv4_valid !== 1'b1 || bus.out_data !== 8'h5A) begin
      fails++; $display("FAIL midfwd_beat: got iv=%b d=%h want iv=1 d=5a", bus.ipv4_valid, bus.out_data);
    end
    resetn = 1'b0;
    bus.rx_valid = 1'b0;
    #1 check_all_zero("reset_async");
    m_arp = 0; m_ip = 0; m_drop = 0; pend_abort = 0;
    got_q.delete(); exp_q.delete();
    @(posedge clk); @(posedge clk); #1 resetn = 1'b1;
    for (int i = 31; i < 64; i++) drive(fbyte(20, i, vecs[20]), 1'b0, i == 63, 1'b0);
    idle(3);
    tests++;
    if (got_q.size() != 0) begin
      fails++; $display("FAIL tail_ignored: got %0d beats want 0", got_q.size());
    end
    check_cnt(-2);
    got_q.delete();
    send_frame(21);
    check_frame(21);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
